alarm_entry: RTL

ALARM_ENTRY -- requirements
Module: alarm_entry

---
 rtl/alarm_entry.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/alarm_entry.sv
// Alarm-time keypad entry: collects up to four BCD digits, validates
// the HH:MM value on ALARM and pulses a load into the alarm register.
module alarm_entry #(
  parameter int TIMEOUT_SEC = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic       key_valid,
  input  logic [3:0] key,
  output logic [3:0] new_alarm_ms_hr,
  output logic [3:0] new_alarm_ls_hr,
  output logic [3:0] new_alarm_ms_min,
  output logic [3:0] new_alarm_ls_min,
  output logic       load_new_alarm,
  output logic       entry_active,
  output logic       entry_error
);

  localparam int CLW = $clog2(TIMEOUT_SEC + 1);
  localparam int CW  = (CLW > 4) ? CLW : 4;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_SEC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTRY,
    S_COMMIT
  } state_t;

  state_t        r_state;
  state_t        w_state;
  logic [3:0]    r_ms_hr;
  logic [3:0]    r_ls_hr;
  logic [3:0]    r_ms_min;
  logic [3:0]    r_ls_min;
  logic [3:0]    w_ms_hr;
  logic [3:0]    w_ls_hr;
  logic [3:0]    w_ms_min;
  logic [3:0]    w_ls_min;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt;
  logic [CW-1:0] w_cnt_inc;
  logic          r_err;
  logic          w_err;

  logic w_digit;
  logic w_alarm;
  logic w_cancel;
  logic w_tick;
  logic w_valid;

  assign w_digit  = key_valid && (key <= 4'd9);
  assign w_alarm  = key_valid && (key == 4'hA);
  assign w_cancel = key_valid && (key == 4'hB);
  // a meaningful key in the same cycle swallows the tick
  assign w_tick   = one_second && !w_digit
                 && !w_alarm && !w_cancel;

  assign w_cnt_inc = (r_cnt == TMAX) ? r_cnt
                   : r_cnt + CW'(1);

  assign w_valid = (r_ms_hr  <= 4'd2)
                && (r_ls_hr  <= 4'd9)
                && (r_ms_min <= 4'd5)
                && (r_ls_min <= 4'd9)
                && !((r_ms_hr == 4'd2)
                  && (r_ls_hr > 4'd3));

  always_comb begin
    w_state  = r_state;
    w_ms_hr  = r_ms_hr;
    w_ls_hr  = r_ls_hr;
    w_ms_min = r_ms_min;
    w_ls_min = r_ls_min;
    w_cnt    = r_cnt;
    w_err    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_digit) begin
          w_ms_hr  = r_ls_hr;
          w_ls_hr  = r_ms_min;
          w_ms_min = r_ls_min;
          w_ls_min = key;
          w_cnt    = '0;
          w_state  = S_ENTRY;
        end
      end
      S_ENTRY: begin
        unique case (1'b1)
          w_digit: begin
            w_ms_hr  = r_ls_hr;
            w_ls_hr  = r_ms_min;
            w_ms_min = r_ls_min;
            w_ls_min = key;
            w_cnt    = '0;
          end
          w_cancel: begin
            w_ms_hr  = '0;
            w_ls_hr  = '0;
            w_ms_min = '0;
            w_ls_min = '0;
            w_cnt    = '0;
            w_state  = S_IDLE;
          end
          w_alarm: begin
            w_cnt = '0;
            if (w_valid) begin
              w_state = S_COMMIT;
            end else begin
              w_err    = 1'b1;
              w_ms_hr  = '0;
              w_ls_hr  = '0;
              w_ms_min = '0;
              w_ls_min = '0;
              w_state  = S_IDLE;
            end
          end
          w_tick: begin
            if (w_cnt_inc >= TMAX) begin
              w_ms_hr  = '0;
              w_ls_hr  = '0;
              w_ms_min = '0;
              w_ls_min = '0;
              w_cnt    = '0;
              w_state  = S_IDLE;
            end else begin
              w_cnt = w_cnt_inc;
            end
          end
          default: begin
          end
        endcase
      end
      S_COMMIT: begin
        w_ms_hr  = '0;
        w_ls_hr  = '0;
        w_ms_min = '0;
        w_ls_min = '0;
        w_cnt    = '0;
        w_state  = S_IDLE;
      end
      default: begin
        w_ms_hr  = '0;
        w_ls_hr  = '0;
        w_ms_min = '0;
        w_ls_min = '0;
        w_cnt    = '0;
        w_state  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_ms_hr  <= '0;
      r_ls_hr  <= '0;
      r_ms_min <= '0;
      r_ls_min <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_ms_hr  <= w_ms_hr;
      r_ls_hr  <= w_ls_hr;
      r_ms_min <= w_ms_min;
      r_ls_min <= w_ls_min;
      r_cnt    <= w_cnt;
      r_err    <= w_err;
    end
  end

  assign new_alarm_ms_hr  = r_ms_hr;
  assign new_alarm_ls_hr  = r_ls_hr;
  assign new_alarm_ms_min = r_ms_min;
  assign new_alarm_ls_min = r_ls_min;
  assign load_new_alarm   = (r_state == S_COMMIT);
  assign entry_active     = (r_state != S_IDLE);
  assign entry_error      = r_err;

endmodule
